// File: rtl/fifo_ecc_pkg.sv
// Shared widths, Hamming position map and decode result type for the ECC FIFO read path.
package fifo_ecc_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ECC_WIDTH  = 7;
    localparam int CW_WIDTH   = DATA_WIDTH + ECC_WIDTH;
    localparam int NPOS       = 38;
    localparam int SYN_WIDTH  = 6;

    // Hamming position of each data bit: every index 3..38 that is not a power of two.
    localparam int DATA_POS [DATA_WIDTH] = '{
        3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15,
        17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31,
        33, 34, 35, 36, 37, 38
    };

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sec;
        logic                  ded;
    } ecc_res_t;

endpackage

// File: rtl/fifo_ecc_rd_pipe_if.sv
// Storage-side and consumer-side signals of the ECC read pipeline.
interface fifo_ecc_rd_pipe_if
    import fifo_ecc_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) ();

    logic                  fifo_empty;
    logic                  mem_rd_en;
    logic [CW_WIDTH-1:0]   mem_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sec;
    logic                  out_ded;
    logic [CNT_WIDTH-1:0]  sec_cnt;
    logic [CNT_WIDTH-1:0]  ded_cnt;
    logic                  cnt_clr;

    modport master (
        input  fifo_empty, mem_rdata, out_ready, cnt_clr,
        output mem_rd_en, out_valid, out_data, out_sec, out_ded, sec_cnt, ded_cnt
    );

    modport slave (
        output fifo_empty, mem_rdata, out_ready, cnt_clr,
        input  mem_rd_en, out_valid, out_data, out_sec, out_ded, sec_cnt, ded_cnt
    );

endinterface

// File: rtl/ecc_secded_chk.sv
// Combinational SEC-DED check: syndrome, overall parity, classification and single-bit correction.
module ecc_secded_chk
    import fifo_ecc_pkg::*;
(
    input  logic [CW_WIDTH-1:0] cw_i,
    output ecc_res_t            res_o
);

    logic [DATA_WIDTH-1:0] data;
    logic [ECC_WIDTH-1:0]  ecc;
    logic [NPOS:1]         vec;
    logic [NPOS:1]         cvec;
    logic [SYN_WIDTH-1:0]  syn;
    logic                  par;
    logic                  in_range;

    assign data = cw_i[DATA_WIDTH-1:0];
    assign ecc  = cw_i[CW_WIDTH-1:DATA_WIDTH];

    always_comb begin
        vec = '0;
        for (int k = 0; k < SYN_WIDTH; k++) begin
            vec[1 << k] = ecc[k+1];
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            vec[DATA_POS[i]] = data[i];
        end
    end

    always_comb begin
        syn = '0;
        for (int p = 1; p <= NPOS; p++) begin
            if (vec[p]) begin
                syn = syn ^ SYN_WIDTH'(p);
            end
        end
    end

    assign par      = (^vec) ^ ecc[0];
    assign in_range = (syn <= SYN_WIDTH'(NPOS));

    // syn==0 with odd parity means only ecc[0] flipped: nothing in vec to correct.
    always_comb begin
        cvec = vec;
        for (int p = 1; p <= NPOS; p++) begin
            if (par && syn == SYN_WIDTH'(p)) begin
                cvec[p] = ~vec[p];
            end
        end
    end

    always_comb begin
        res_o.sec = par && in_range;
        res_o.ded = (par && !in_range) || (!par && syn != '0);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            res_o.data[i] = cvec[DATA_POS[i]];
        end
        if (res_o.ded) begin
            res_o.data = data;
        end
    end

endmodule

// File: rtl/fifo_ecc_rd_pipe.sv
// ECC FIFO read stage: pops storage, decodes one cycle later into a 2-entry output buffer, counts errors.
module fifo_ecc_rd_pipe
    import fifo_ecc_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_ecc_rd_pipe_if.master bus
);

    ecc_res_t             dec;
    ecc_res_t             buf_q [2];
    logic                 inflight_q;
    logic [1:0]           count_q;
    logic                 rd_ptr_q;
    logic                 wr_ptr_q;
    logic [CNT_WIDTH-1:0] sec_cnt_q;
    logic [CNT_WIDTH-1:0] sec_cnt_d;
    logic [CNT_WIDTH-1:0] ded_cnt_q;
    logic [CNT_WIDTH-1:0] ded_cnt_d;
    logic                 pop;
    logic                 wr;
    logic                 issue;
    logic [2:0]           occ;

    ecc_secded_chk u_chk (
        .cw_i  (bus.mem_rdata),
        .res_o (dec)
    );

    assign pop = (count_q != 2'd0) && bus.out_ready;
    assign wr  = inflight_q;

    // Count the word already requested from storage as occupying a slot so the buffer never overflows.
    assign occ   = 3'(inflight_q) + 3'(count_q) - 3'(pop);
    assign issue = rst_n && !bus.fifo_empty && (occ < 3'd2);

    always_comb begin
        sec_cnt_d = sec_cnt_q;
        ded_cnt_d = ded_cnt_q;
        if (bus.cnt_clr) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else if (wr) begin
            if (dec.sec && sec_cnt_q != '1) begin
                sec_cnt_d = sec_cnt_q + CNT_WIDTH'(1);
            end
            if (dec.ded && ded_cnt_q != '1) begin
                ded_cnt_d = ded_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
        end else begin
            inflight_q <= issue;
            if (wr) begin
                buf_q[wr_ptr_q] <= dec;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q   <= count_q + 2'(wr) - 2'(pop);
            sec_cnt_q <= sec_cnt_d;
            ded_cnt_q <= ded_cnt_d;
        end
    end

    assign bus.mem_rd_en = issue;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = buf_q[rd_ptr_q].data;
    assign bus.out_sec   = buf_q[rd_ptr_q].sec;
    assign bus.out_ded   = buf_q[rd_ptr_q].ded;
    assign bus.sec_cnt   = sec_cnt_q;
    assign bus.ded_cnt   = ded_cnt_q;

endmodule

// File: tb/tb_fifo_ecc_rd_pipe.sv
// Directed bench for fifo_ecc_rd_pipe with a queue-backed storage model and 2-bit counters.
module tb_fifo_ecc_rd_pipe;
    import fifo_ecc_pkg::*;

    localparam int CNTW = 2;

    logic clk;
    logic rst_n;

    fifo_ecc_rd_pipe_if #(.CNT_WIDTH(CNTW)) bus ();

    fifo_ecc_rd_pipe #(.CNT_WIDTH(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [CW_WIDTH-1:0]   mem_q [$];
    logic [DATA_WIDTH-1:0] got_q [$];
    logic                  re_s, ov_s, pop_s, sec_s, ded_s;
    logic [DATA_WIDTH-1:0] od_s;
    int                    re_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [ECC_WIDTH-1:0] ecc, input logic [DATA_WIDTH-1:0] data);
        mem_q.push_back({ecc, data});
        bus.fifo_empty = 1'b0;
    endtask

    // Entered one time unit after a rising edge; samples just before the next edge, then models storage.
    task automatic cycle();
        logic re;
        #3;
        re    = bus.mem_rd_en;
        re_s  = re;
        ov_s  = bus.out_valid;
        pop_s = bus.out_valid && bus.out_ready;
        od_s  = bus.out_data;
        sec_s = bus.out_sec;
        ded_s = bus.out_ded;
        if (re) re_cnt++;
        if (pop_s) got_q.push_back(bus.out_data);
        @(posedge clk);
        #1;
        if (re && mem_q.size() != 0) bus.mem_rdata = mem_q.pop_front();
        bus.fifo_empty = (mem_q.size() == 0);
    endtask

    task automatic expect_word(input string tag, input logic [DATA_WIDTH-1:0] d,
                               input logic s, input logic e);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            seen = pop_s;
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        chk({tag, "_data"}, 64'(od_s), 64'(d));
        chk({tag, "_sec"},  64'(sec_s), 64'(s));
        chk({tag, "_ded"},  64'(ded_s), 64'(e));
    endtask

    logic [DATA_WIDTH-1:0] bp_exp [8];
    int                    re_base;

    initial begin
        rst_n          = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.mem_rdata  = '0;
        bus.out_ready  = 1'b0;
        bus.cnt_clr    = 1'b0;
        #2;
        chk("rst_rd_en",   64'(bus.mem_rd_en), 64'd0);
        chk("rst_valid",   64'(bus.out_valid), 64'd0);
        chk("rst_data",    64'(bus.out_data),  64'd0);
        chk("rst_sec",     64'(bus.out_sec),   64'd0);
        chk("rst_ded",     64'(bus.out_ded),   64'd0);
        chk("rst_sec_cnt", 64'(bus.sec_cnt),   64'd0);
        chk("rst_ded_cnt", 64'(bus.ded_cnt),   64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

        // Latency: issue at N, valid at N+2.
        push(7'h00, 32'h0000_0000);
        cycle();
        chk("lat_issue_n",  64'(re_s), 64'd1);
        chk("lat_valid_n",  64'(ov_s), 64'd0);
        cycle();
        chk("lat_valid_n1", 64'(ov_s), 64'd0);
        cycle();
        chk("lat_valid_n2", 64'(ov_s),  64'd1);
        chk("lat_data",     64'(od_s),  64'd0);
        chk("lat_sec",      64'(sec_s), 64'd0);
        chk("lat_ded",      64'(ded_s), 64'd0);
        cycle();
        chk("lat_drained",  64'(ov_s), 64'd0);
        chk("clean_sec_cnt", 64'(bus.sec_cnt), 64'd0);
        chk("clean_ded_cnt", 64'(bus.ded_cnt), 64'd0);

        push(7'h00, 32'h0000_0001);
        expect_word("sec_d3", 32'h0, 1'b1, 1'b0);
        chk("sec_cnt_1", 64'(bus.sec_cnt), 64'd1);

        push(7'h00, 32'h0000_0003);
        expect_word("ded_s6", 32'h3, 1'b0, 1'b1);
        chk("ded_cnt_1", 64'(bus.ded_cnt), 64'd1);

        push(7'h01, 32'h0000_0000);
        expect_word("sec_p0", 32'h0, 1'b1, 1'b0);
        chk("sec_cnt_2", 64'(bus.sec_cnt), 64'd2);

        push(7'h07, 32'h0000_0001);
        expect_word("clean_d1", 32'h1, 1'b0, 1'b0);

        push(7'h07, 32'h0000_0003);
        expect_word("sec_fix_d1", 32'h1, 1'b1, 1'b0);
        chk("sec_cnt_3", 64'(bus.sec_cnt), 64'd3);

        // Odd parity with syndrome 60 is beyond the codeword: raw data passed through.
        push(7'h7E, 32'h0000_0001);
        expect_word("ded_s60", 32'h1, 1'b0, 1'b1);
        chk("ded_cnt_2", 64'(bus.ded_cnt), 64'd2);

        push(7'h00, 32'h0000_0002);
        expect_word("sec_sat", 32'h0, 1'b1, 1'b0);
        chk("sec_cnt_sat", 64'(bus.sec_cnt), 64'd3);

        // Clear lands on the same edge as a sec write.
        push(7'h00, 32'h0000_0001);
        cycle();
        chk("clr_issue", 64'(re_s), 64'd1);
        bus.cnt_clr = 1'b1;
        cycle();
        bus.cnt_clr = 1'b0;
        chk("clr_sec_cnt", 64'(bus.sec_cnt), 64'd0);
        chk("clr_ded_cnt", 64'(bus.ded_cnt), 64'd0);
        cycle();
        chk("clr_word_valid", 64'(pop_s), 64'd1);
        chk("clr_word_sec",   64'(sec_s), 64'd1);
        push(7'h00, 32'h0000_0001);
        expect_word("after_clr", 32'h0, 1'b1, 1'b0);
        chk("after_clr_cnt", 64'(bus.sec_cnt), 64'd1);

        // Backpressure: eight clean words, consumer stalled for five cycles.
        bp_exp = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h3, 32'h20, 32'h0};
        bus.out_ready = 1'b0;
        push(7'h07, 32'h0000_0001);
        push(7'h0B, 32'h0000_0002);
        push(7'h0D, 32'h0000_0004);
        push(7'h0E, 32'h0000_0008);
        push(7'h13, 32'h0000_0010);
        push(7'h0C, 32'h0000_0003);
        push(7'h15, 32'h0000_0020);
        push(7'h00, 32'h0000_0000);
        got_q.delete();
        re_base = re_cnt;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (i == 2) chk("bp_hold_c3", 64'(od_s), 64'h1);
        end
        chk("bp_issue_cnt", 64'(re_cnt - re_base), 64'd2);
        chk("bp_valid",     64'(ov_s), 64'd1);
        chk("bp_hold_c5",   64'(od_s), 64'h1);
        chk("bp_no_issue",  64'(re_s), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk($sformatf("bp_flags_%0d", i), 64'({sec_s, ded_s}), 64'd0);
        end
        chk("bp_count", 64'(got_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_q.size()) chk($sformatf("bp_word_%0d", i), 64'(got_q[i]), 64'(bp_exp[i]));
        end
        cycle();
        chk("bp_drained", 64'(ov_s), 64'd0);

        // Reset with words buffered: they must never come out.
        bus.out_ready = 1'b0;
        push(7'h07, 32'h0000_0001);
        push(7'h0B, 32'h0000_0002);
        for (int i = 0; i < 4; i++) cycle();
        chk("mid_pre_valid", 64'(ov_s), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",   64'(bus.out_valid), 64'd0);
        chk("mid_rst_sec_cnt", 64'(bus.sec_cnt),   64'd0);
        chk("mid_rst_data",    64'(bus.out_data),  64'd0);
        cycle();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 4; i++) cycle();
        chk("mid_no_delivery", 64'(got_q.size()), 64'd0);
        push(7'h0E, 32'h0000_0008);
        expect_word("post_rst", 32'h8, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
